imem_responder: RTL and testbench

- Instruction-memory responder on the far end of the fetch request channel.
- Accepts word-fetch requests from the fetch unit over a valid/ready handshake.
- Returns instruction words in request order after a fixed read latency, through a bounded response queue that absorbs back-pressure from the IF/ID stage.
- Supports a flush for redirects, and a loader write port used to preload programs.

---
 rtl/imem_responder.sv | 141 ++++++++++++++
 tb/tb_imem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with fixed read latency and credit-bounded response queue
module imem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_fault,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [31:0]           mem_q [0:(1<<ADDR_WIDTH)-1];

    // Read pipeline: one slot per latency cycle, valid bits reset, payload not
    logic [LATENCY-1:0]    pv_q;
    logic [31:0]           pd_q [LATENCY];
    logic                  pf_q [LATENCY];

    // Response queue storage and bookkeeping
    logic [31:0]           qd_q [DEPTH];
    logic                  qf_q [DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         qcnt_q, qcnt_d;
    logic [CW-1:0]         occ_q, occ_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_fault;
    logic                  accept;
    logic                  consume;
    logic                  push;

    assign word_idx   = req_addr[ADDR_WIDTH+1:2];
    assign addr_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);

    // Credit is taken from registered occupancy; reset_n gating keeps ready low while held in reset
    assign req_ready  = reset_n && (occ_q < CW'(DEPTH)) && !flush;
    assign resp_valid = (qcnt_q != '0);
    assign resp_data  = resp_valid ? qd_q[rd_q] : '0;
    assign resp_fault = resp_valid ? qf_q[rd_q] : 1'b0;

    assign accept  = req_valid && req_ready;
    assign consume = resp_valid && resp_ready && !flush;
    assign push    = pv_q[LATENCY-1] && !flush;

    // Next-state for occupancy and queue count; flush wins over accept/consume
    always_comb begin
        occ_d  = occ_q;
        qcnt_d = qcnt_q;
        if (flush) begin
            occ_d  = '0;
            qcnt_d = '0;
        end else begin
            if (accept && !consume) begin
                occ_d = occ_q + CW'(1);
            end else if (!accept && consume) begin
                occ_d = occ_q - CW'(1);
            end
            if (push && !consume) begin
                qcnt_d = qcnt_q + CW'(1);
            end else if (!push && consume) begin
                qcnt_d = qcnt_q - CW'(1);
            end
        end
    end

    // Loader write port; independent of handshake, flush and reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Pipeline valid bits shift toward the queue; flush and reset kill in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q <= '0;
        end else if (flush) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    // Pipeline payload: memory sampled at the accept edge, so a same-edge load returns old data
    always_ff @(posedge clk) begin
        pd_q[0] <= addr_fault ? NOP_WORD : mem_q[word_idx];
        pf_q[0] <= addr_fault;
        for (int i = 1; i < LATENCY; i++) begin
            pd_q[i] <= pd_q[i-1];
            pf_q[i] <= pf_q[i-1];
        end
    end

    // Queue payload write at the tail of the pipeline
    always_ff @(posedge clk) begin
        if (push) begin
            qd_q[wr_q] <= pd_q[LATENCY-1];
            qf_q[wr_q] <= pf_q[LATENCY-1];
        end
    end

    // Pointers and counters; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            qcnt_q <= '0;
            occ_q  <= '0;
        end else begin
            qcnt_q <= qcnt_d;
            occ_q  <= occ_d;
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    wr_q <= wr_q + PW'(1);
                end
                if (consume) begin
                    rd_q <= rd_q + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder against a queue-based model
module tb_imem_responder;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          resp_ready = 1'b0;
    logic          flush = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic          resp_fault;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_fault(resp_fault),
        .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          avail;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] mem_m [0:(1<<AW)-1];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge against the model, then advance the model
    task automatic step(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                        input logic le, input logic [AW-1:0] la, input logic [31:0] ld);
        bit   mv;
        bit   mr;
        bit   flt;
        ent_t e;
        req_valid  = rv;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        load_en    = le;
        load_addr  = la;
        load_data  = ld;
        @(negedge clk);
        mv = (pend.size() > 0) && (pend[0].avail <= cyc);
        mr = (pend.size() < DEP) && !fl;
        check_val("req_ready", {31'b0, req_ready}, {31'b0, mr});
        check_val("resp_valid", {31'b0, resp_valid}, {31'b0, mv});
        if (mv && resp_valid) begin
            check_val("resp_data", resp_data, pend[0].data);
            check_val("resp_fault", {31'b0, resp_fault}, {31'b0, pend[0].fault});
        end
        @(posedge clk);
        cyc++;
        if (fl) begin
            pend.delete();
        end else begin
            if (mv && rr) void'(pend.pop_front());
            if (rv && mr) begin
                flt = (a % 4 != 0) || ((a >> (AW + 2)) != 0);
                e.fault = flt;
                e.data  = flt ? 32'h0000_0013 : mem_m[(a >> 2) % (1 << AW)];
                e.avail = cyc + LAT;
                pend.push_back(e);
            end
        end
        if (le) mem_m[la] = ld;
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 1'b0, '0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
        check_val({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
        check_val({tag, "_resp_data"}, resp_data, 32'h0);
        check_val({tag, "_resp_fault"}, {31'b0, resp_fault}, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] idx;
        r   = $urandom_range(0, 9);
        idx = 32'($urandom_range(0, 63));
        if (r == 0) return (idx << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return (32'($urandom_range(1, 1023)) << (AW + 2)) | (idx << 2);
        return idx << 2;
    endfunction

    initial begin
        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload words 0..63, word 5 = 0x00A00093
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), (i == 5) ? 32'h00A0_0093 : $urandom);
        end

        // Single fetch of 0x14
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Streaming 0x00..0x1C at full throughput
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Back-pressure fills the credit, then drains
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, '0, 32'h0);
        idle(6, 1'b1);

        // Faulting addresses
        step(1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        step(1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Same-edge load and fetch of word 5 returns old data; later fetch sees new data
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF);
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Flush with responses queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, '0, 32'h0);
        idle(2, 1'b0);
        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, '0, 32'h0);
        idle(5, 1'b1);
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Reset with three outstanding requests
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4 + 8), 1'b0, 1'b0, 1'b0, '0, 32'h0);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pend.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(5, 1'b1);
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        step(1'b1, 32'h00, 1'b1, 1'b0, 1'b0, '0, 32'h0);
        idle(4, 1'b1);

        // Randomized traffic with back-pressure, flushes and concurrent loads
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
                 AW'($urandom_range(0, 63)), $urandom);
        end
        idle(8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
